// File: rtl/move_ctrl_if.sv
// Board-tile handshake: move_ctrl drives the master side, the input/tile logic the slave side.
interface move_ctrl_if;
  logic        confirm;
  logic [3:0]  cursor;
  logic [17:0] board;
  logic [8:0]  sel;
  logic        turn;
  logic        busy;
  logic        err;
  logic        game_over;
  logic [1:0]  winner;
  logic        timeout;

  modport master (
    input  confirm, cursor, board,
    output sel, turn, busy, err, game_over, winner, timeout
  );
  modport slave (
    output confirm, cursor, board,
    input  sel, turn, busy, err, game_over, winner, timeout
  );
endinterface

// File: rtl/move_ctrl.sv
// Tic-tac-toe move controller: validates a cursor move, selects the tile, then scores the board.
// Optional MOVE_TIMEOUT_EN adds a per-move forfeit timer of TIMEOUT_CYCLES clocks.
module move_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  move_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, CHECK, COMMIT, SETTLE, EVAL, DONE} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("move_ctrl: TIMEOUT_CYCLES must be non-zero");
  end

  state_e     state_q;
  logic [3:0] tgt_q;
  logic [3:0] moves_q;
  logic [3:0] moves_d;
  logic [8:0] sel_q;
  logic       turn_q;
  logic       busy_q;
  logic       err_q;
  logic       over_q;
  logic [1:0] winner_q;

  logic [1:0] tile [9];
  logic [1:0] line [8];
  logic [1:0] line_win;
  logic       tgt_free;

  // 11 tiles never win: only 01/10 triples count.
  function automatic logic [1:0] line_sym(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
    return (a == b && b == c && (a == 2'b01 || a == 2'b10)) ? a : 2'b00;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) tile[i] = bus.board[2*i +: 2];
    line[0] = line_sym(tile[0], tile[1], tile[2]);
    line[1] = line_sym(tile[3], tile[4], tile[5]);
    line[2] = line_sym(tile[6], tile[7], tile[8]);
    line[3] = line_sym(tile[0], tile[3], tile[6]);
    line[4] = line_sym(tile[1], tile[4], tile[7]);
    line[5] = line_sym(tile[2], tile[5], tile[8]);
    line[6] = line_sym(tile[0], tile[4], tile[8]);
    line[7] = line_sym(tile[2], tile[4], tile[6]);
    line_win = 2'b00;
    for (int i = 7; i >= 0; i--) if (line[i] != 2'b00) line_win = line[i];
    tgt_free = 1'b0;
    if (tgt_q < 4'd9) tgt_free = (tile[tgt_q] == 2'b00);
    moves_d = (moves_q == 4'd9) ? 4'd9 : moves_q + 4'd1;
  end

`ifdef MOVE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt_q;
  logic        to_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      moves_q  <= '0;
      sel_q    <= '0;
      turn_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
`ifdef MOVE_TIMEOUT_EN
      to_q       <= 1'b0;
      idle_cnt_q <= '0;
`endif
    end else begin
      sel_q <= '0;
      err_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      to_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.confirm && !over_q) begin
            tgt_q   <= bus.cursor;
            busy_q  <= 1'b1;
            state_q <= CHECK;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
`ifdef MOVE_TIMEOUT_EN
          else if (idle_cnt_q == TO_LAST) begin
            to_q       <= 1'b1;
            turn_q     <= ~turn_q;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
`endif
        end
        CHECK: begin
          if (tgt_free) begin
            sel_q   <= 9'd1 << tgt_q;
            state_q <= COMMIT;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        COMMIT: state_q <= SETTLE;
        // Tile has latched the move by now, so score here and expose the result during EVAL.
        SETTLE: begin
          state_q <= EVAL;
          if (line_win != 2'b00) begin
            winner_q <= line_win;
            over_q   <= 1'b1;
          end else begin
            moves_q <= moves_d;
            if (moves_d == 4'd9) over_q <= 1'b1;
            else                 turn_q <= ~turn_q;
          end
        end
        EVAL: begin
          busy_q  <= 1'b0;
          state_q <= over_q ? DONE : IDLE;
`ifdef MOVE_TIMEOUT_EN
          idle_cnt_q <= '0;
`endif
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.turn      = turn_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.game_over = over_q;
  assign bus.winner    = winner_q;
`ifdef MOVE_TIMEOUT_EN
  assign bus.timeout   = to_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: a per-cycle expectation timeline built from game rules, plus directed literal checks.
module tb_move_ctrl;
  localparam int MAXC = 8192;
  localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_ctrl_if mif();
  move_ctrl dut (.clk(clk), .reset(reset), .bus(mif));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs indexed by cycle number
  bit [8:0] e_sel  [MAXC];
  bit       e_err  [MAXC];
  bit       e_busy [MAXC];
  bit       e_turn [MAXC];
  bit       e_go   [MAXC];
  bit [1:0] e_win  [MAXC];

  bit [1:0] mb [9];
  int       m_ready = 0;
  int       m_cnt   = 0;
  bit       m_turn  = 1'b0;
  bit       m_go    = 1'b0;
  bit [1:0] m_win   = 2'b00;
  bit       pend_v  = 1'b0;
  int       pend_at, pend_tile;
  bit [1:0] pend_sym;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk)
    if (cyc < MAXC)
      chk("outputs", 32'({mif.sel, mif.turn, mif.busy, mif.err, mif.game_over, mif.winner, mif.timeout}),
          32'({e_sel[cyc], e_turn[cyc], e_busy[cyc], e_err[cyc], e_go[cyc], e_win[cyc], 1'b0}));

  function automatic bit [1:0] winner_of(input bit [1:0] b [9]);
    for (int l = 0; l < 8; l++) begin
      if ((b[LN[l][0]] == 2'b01 || b[LN[l][0]] == 2'b10) &&
          b[LN[l][0]] == b[LN[l][1]] && b[LN[l][1]] == b[LN[l][2]])
        return b[LN[l][0]];
    end
    return 2'b00;
  endfunction

  function automatic logic [17:0] pack_board(input bit [1:0] b [9]);
    logic [17:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[2*i +: 2] = b[i];
    return p;
  endfunction

  // Drive one cycle of inputs, extend the expected timeline, then advance to the next negedge.
  task automatic step(input bit r, input bit cf, input bit [3:0] cu);
    int k;
    bit [1:0] nb [9];
    bit [1:0] sym, w;
    k = cyc;
    if (pend_v && pend_at == k) begin
      mb[pend_tile] = pend_sym;
      pend_v = 1'b0;
    end
    reset = r; mif.confirm = cf; mif.cursor = cu; mif.board = pack_board(mb);
    if (r) begin
      for (int i = k + 1; i < MAXC; i++) begin
        e_sel[i] = '0; e_err[i] = 0; e_busy[i] = 0; e_turn[i] = 0; e_go[i] = 0; e_win[i] = '0;
      end
      m_ready = k + 1; m_turn = 0; m_go = 0; m_win = 2'b00; m_cnt = 0; pend_v = 0;
    end else if (cf && k >= m_ready && !m_go) begin
      e_busy[k+1] = 1;
      if (cu > 8 || mb[cu] != 2'b00) begin
        e_err[k+2] = 1;
        m_ready = k + 2;
      end else begin
        sym = m_turn ? 2'b10 : 2'b01;
        for (int i = k + 2; i <= k + 4; i++) e_busy[i] = 1;
        e_sel[k+2] = 9'b1 << cu;
        pend_v = 1; pend_at = k + 3; pend_tile = int'(cu); pend_sym = sym;
        nb = mb;
        nb[cu] = sym;
        w = winner_of(nb);
        if (m_cnt < 9) m_cnt++;
        if (w != 2'b00) begin m_go = 1; m_win = w; end
        else if (m_cnt == 9) begin m_go = 1; m_win = 2'b00; end
        else m_turn = !m_turn;
        for (int i = k + 4; i < MAXC; i++) begin
          e_turn[i] = m_turn; e_go[i] = m_go; e_win[i] = m_win;
        end
        m_ready = k + 5;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic new_game(input bit [1:0] b [9]);
    mb = b;
    step(1'b1, 1'b0, 4'd0);
  endtask

  task automatic play(input int unsigned cu);
    step(1'b0, 1'b1, 4'(cu));
    idle(4);
  endtask

  task automatic rand_board(output bit [1:0] b [9]);
    do begin
      for (int i = 0; i < 9; i++) begin
        int r;
        r = int'($urandom_range(0, 11));
        b[i] = (r == 9) ? 2'b01 : (r == 10) ? 2'b10 : (r == 11) ? 2'b11 : 2'b00;
      end
    end while (winner_of(b) != 2'b00);
  endtask

  initial begin
    bit [1:0] eb [9];
    bit [1:0] nb [9];
    int c;
    int unsigned win_seq [5]  = '{0, 3, 1, 4, 2};
    int unsigned draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int i = 0; i < 9; i++) eb[i] = 2'b00;

    new_game(eb);
    step(1'b1, 1'b0, 4'd0);
    chk("reset_state", 32'({mif.sel, mif.turn, mif.busy, mif.err, mif.game_over, mif.winner, mif.timeout}), 32'd0);
    idle(2);

    // first move: centre tile, sel two cycles after confirm, turn flips two cycles later
    c = cyc;
    step(1'b0, 1'b1, 4'd4);
    idle(1);
    chk("first_sel", 32'(mif.sel), 32'h010);
    chk("first_turn_hold", 32'(mif.turn), 32'd0);
    chk("pin_model_sel", 32'(e_sel[c+2]), 32'h010);
    idle(2);
    chk("first_turn_next", 32'(mif.turn), 32'd1);
    idle(2);

    // occupied tile
    nb = eb;
    nb[4] = 2'b01;
    new_game(nb);
    idle(1);
    step(1'b0, 1'b1, 4'd4);
    idle(1);
    chk("occ_err", 32'(mif.err), 32'd1);
    chk("occ_sel", 32'(mif.sel), 32'd0);
    chk("occ_turn", 32'(mif.turn), 32'd0);
    idle(1);
    chk("occ_err_once", 32'(mif.err), 32'd0);

    // out-of-range cursor
    step(1'b0, 1'b1, 4'd9);
    idle(1);
    chk("range_err", 32'(mif.err), 32'd1);
    chk("range_sel", 32'(mif.sel), 32'd0);
    idle(2);

    // X wins on the top row
    new_game(eb);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("win_not_yet", 32'(mif.game_over), 32'd0);
      play(win_seq[i]);
    end
    chk("win_over", 32'(mif.game_over), 32'd1);
    chk("win_sym", 32'(mif.winner), 32'd1);
    chk("pin_model_win", 32'(e_win[cyc]), 32'd1);
    step(1'b0, 1'b1, 4'd8);
    idle(1);
    chk("done_sel", 32'(mif.sel), 32'd0);
    chk("done_err", 32'(mif.err), 32'd0);
    idle(2);
    chk("done_busy", 32'(mif.busy), 32'd0);

    // draw after nine moves
    new_game(eb);
    idle(1);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("draw_not_yet", 32'(mif.game_over), 32'd0);
      play(draw_seq[i]);
    end
    chk("draw_over", 32'(mif.game_over), 32'd1);
    chk("draw_winner", 32'(mif.winner), 32'd0);

    // reset landing on the COMMIT cycle
    new_game(eb);
    idle(1);
    step(1'b0, 1'b1, 4'd2);
    idle(1);
    chk("commit_sel", 32'(mif.sel), 32'h004);
    step(1'b1, 1'b0, 4'd0);
    chk("commit_reset", 32'({mif.sel, mif.turn, mif.busy, mif.err, mif.game_over, mif.winner, mif.timeout}), 32'd0);
    idle(3);
    chk("commit_no_sel", 32'(mif.sel), 32'd0);

    // random games on random prefilled boards, with stray confirms and occasional resets
    for (int g = 0; g < 40 && cyc < 7000; g++) begin
      rand_board(nb);
      new_game(nb);
      for (int t = 0; t < 120 && cyc < 7400; t++) begin
        bit r, cf;
        bit [3:0] cu;
        r  = ($urandom_range(0, 299) == 0);
        cf = ($urandom_range(0, 2) == 0);
        cu = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        step(r, cf, cu);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
